// File: rtl/lq_agen_csadd_pkg.sv
// Shared constants and helpers for the LQ carry-select address adder.
// Default geometry, mode32 split point and group-width sanity check.
package lq_agen_csadd_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int GRP_DEF   = 4;
  localparam int M32_BITS  = 32;

  function automatic int ngrp(input int w, input int g);
    return w / g;
  endfunction

  function automatic int split32(input int w);
    return w - M32_BITS;
  endfunction

  function automatic bit grp_ok(input int w, input int g);
    return (g > 0) && (w % g == 0);
  endfunction

endpackage

// File: rtl/lq_agen_csadd_pipe_csgrp.sv
// One carry-select group: sums for carry-in 0 and 1, group gen/prop.
// Ports: a, b (GRP, bit 0 MSB) -> s0, s1 (GRP), gg, gp.
module lq_agen_csgrp
  import lq_agen_csadd_pkg::*;
#(
  parameter int GRP = GRP_DEF
) (
  input  logic [0:GRP-1] a,
  input  logic [0:GRP-1] b,
  output logic [0:GRP-1] s0,
  output logic [0:GRP-1] s1,
  output logic           gg,
  output logic           gp
);

  logic [0:GRP] t0;

  assign t0 = {1'b0, a} + {1'b0, b};
  assign s0 = t0[1:GRP];
  assign s1 = a + b + GRP'(1);
  assign gg = t0[0];
  assign gp = &(a ^ b);

endmodule

// File: rtl/lq_agen_csadd_pipe.sv
// Two-stage pipelined carry-select EA adder: ea = base + offset + ci.
// Ports: clk, rst_b, in_* (vld/rdy handshake), out_* (vld/rdy, ea, co).
module lq_agen_csadd_pipe
  import lq_agen_csadd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GRP   = GRP_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [0:WIDTH-1] in_base,
  input  logic [0:WIDTH-1] in_offset,
  input  logic             in_ci,
  input  logic             in_mode32,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [0:WIDTH-1] out_ea,
  output logic             out_co
);

  localparam int NGRP  = ngrp(WIDTH, GRP);
  localparam int SPLIT = split32(WIDTH);
  localparam int G32   = (WIDTH >= 64) ? SPLIT / GRP : 0;

  if (!grp_ok(WIDTH, GRP)) begin : g_bad_grp
    $error("WIDTH must be a multiple of GRP");
  end

  logic [0:WIDTH-1] s0_n, s1_n, s0_a, s1_a;
  logic [0:NGRP-1]  gg_n, gp_n, gg_a, gp_a;
  logic             ci_a, m32_a, vld_a;
  logic [0:NGRP-1]  cc, cin;
  logic [0:WIDTH-1] sum, ea_n;
  logic             co_n, adv_b, acc;

  assign adv_b  = vld_a & (~out_vld | out_rdy);
  assign in_rdy = ~vld_a | adv_b;
  assign acc    = in_vld & in_rdy;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    lq_agen_csgrp #(.GRP(GRP)) u_grp (
      .a  (in_base[g*GRP +: GRP]),
      .b  (in_offset[g*GRP +: GRP]),
      .s0 (s0_n[g*GRP +: GRP]),
      .s1 (s1_n[g*GRP +: GRP]),
      .gg (gg_n[g]),
      .gp (gp_n[g])
    );
    if (g == NGRP - 1) begin : g_lsb
      assign cin[g] = ci_a;
    end else begin : g_up
      assign cin[g] = cc[g+1];
    end
    assign sum[g*GRP +: GRP] = cin[g] ? s1_a[g*GRP +: GRP]
                                      : s0_a[g*GRP +: GRP];
  end

  // cc[g] is the carry out of group g (group 0 holds the MSBs).
  if (NGRP > 8) begin : g_prefix
    // Kogge-Stone over LSB-first indices, ci folded into position 0.
    always_comb begin
      logic [NGRP-1:0] gk, pk, gn, pn;
      for (int i = 0; i < NGRP; i++) begin
        gk[i] = gg_a[NGRP-1-i];
        pk[i] = gp_a[NGRP-1-i];
      end
      gk[0] = gk[0] | (pk[0] & ci_a);
      for (int d = 1; d < NGRP; d = d * 2) begin
        gn = gk;
        pn = pk;
        for (int i = d; i < NGRP; i++) begin
          gn[i] = gk[i] | (pk[i] & gk[i-d]);
          pn[i] = pk[i] & pk[i-d];
        end
        gk = gn;
        pk = pn;
      end
      cc = '0;
      for (int i = 0; i < NGRP; i++) begin
        cc[NGRP-1-i] = gk[i];
      end
    end
  end else begin : g_ripple
    always_comb begin
      logic c;
      c  = ci_a;
      cc = '0;
      for (int g = NGRP - 1; g >= 0; g--) begin
        c     = gg_a[g] | (gp_a[g] & c);
        cc[g] = c;
      end
    end
  end

  if (WIDTH >= 64) begin : g_m32
    if (SPLIT % GRP != 0) begin : g_bad_split
      $error("mode32 split must fall on a group boundary");
    end
    assign ea_n = m32_a ? {{SPLIT{1'b0}}, sum[SPLIT:WIDTH-1]} : sum;
    assign co_n = m32_a ? cc[G32] : cc[0];
  end else begin : g_no_m32
    logic unused_m32;
    assign unused_m32 = m32_a;
    assign ea_n = sum;
    assign co_n = cc[0];
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_a <= 1'b0;
      s0_a  <= '0;
      s1_a  <= '0;
      gg_a  <= '0;
      gp_a  <= '0;
      ci_a  <= 1'b0;
      m32_a <= 1'b0;
    end else if (acc) begin
      vld_a <= 1'b1;
      s0_a  <= s0_n;
      s1_a  <= s1_n;
      gg_a  <= gg_n;
      gp_a  <= gp_n;
      ci_a  <= in_ci;
      m32_a <= in_mode32;
    end else if (adv_b) begin
      vld_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_vld <= 1'b0;
      out_ea  <= '0;
      out_co  <= 1'b0;
    end else if (adv_b) begin
      out_vld <= 1'b1;
      out_ea  <= ea_n;
      out_co  <= co_n;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule
